// File: rtl/mem_bist_pkg.sv
// Shared types for the memory BIST: FSM state encoding, read-pipeline entry and phase sequencing.
// Optional failure log is enabled with the MEM_BIST_FAIL_LOG_EN macro.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLR_WR  = 3'd1,
    CLR_RD  = 3'd2,
    CLR_DRN = 3'd3,
    DA_WR   = 3'd4,
    DA_RD   = 3'd5,
    DA_DRN  = 3'd6,
    DONE    = 3'd7
  } bist_state_t;

  // Entry fields are sized for the widest supported memory; narrower instances zero-extend.
  localparam int PIPE_ADDR_W = 16;
  localparam int PIPE_DATA_W = 64;

  typedef struct packed {
    logic                   vld;
    logic [PIPE_ADDR_W-1:0] addr;
    logic [PIPE_DATA_W-1:0] exp;
  } rd_entry_t;

  function automatic logic is_active(input bist_state_t s);
    return (s != IDLE) && (s != DONE);
  endfunction

  function automatic logic is_drain(input bist_state_t s);
    return (s == CLR_DRN) || (s == DA_DRN);
  endfunction

  function automatic bist_state_t next_phase(input bist_state_t s);
    bist_state_t n;
    case (s)
      CLR_WR:  n = CLR_RD;
      CLR_RD:  n = CLR_DRN;
      CLR_DRN: n = DA_WR;
      DA_WR:   n = DA_RD;
      DA_RD:   n = DA_DRN;
      DA_DRN:  n = DONE;
      default: n = IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_bist_chk.sv
// Read-data checker: RD_LAT-deep expectation pipeline, comparator and miscompare counter.
// With MEM_BIST_FAIL_LOG_EN defined it also latches the first miscompare of a run.
module mem_bist_chk
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              rd_vld_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] rd_exp_i,
  input  logic [DATA_W-1:0] data_out_i,
`ifdef MEM_BIST_FAIL_LOG_EN
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [DATA_W-1:0] fail_exp_o,
  output logic [DATA_W-1:0] fail_act_o,
`endif
  output logic [ADDR_W+1:0] err_cnt_o
);

  rd_entry_t        pipe_q [RD_LAT];
  rd_entry_t        push_w;
  rd_entry_t        pop_w;
  logic             miss_w;
  logic [ADDR_W+1:0] err_q;
  logic [ADDR_W+1:0] err_d;

  always_comb begin
    push_w      = '0;
    push_w.vld  = rd_vld_i;
    push_w.addr = PIPE_ADDR_W'(rd_addr_i);
    push_w.exp  = PIPE_DATA_W'(rd_exp_i);
  end

  // Stage RD_LAT-1 lines up with the cycle the memory presents the data.
  assign pop_w  = pipe_q[RD_LAT-1];
  assign miss_w = pop_w.vld && (pop_w.exp != PIPE_DATA_W'(data_out_i));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= push_w;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_comb begin
    err_d = err_q;
    if (clr_i)       err_d = '0;
    else if (miss_w) err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= err_d;
  end

  assign err_cnt_o = err_q;

`ifdef MEM_BIST_FAIL_LOG_EN
  logic              seen_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [DATA_W-1:0] fail_exp_q;
  logic [DATA_W-1:0] fail_act_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_act_q  <= '0;
    end else if (clr_i) begin
      seen_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_act_q  <= '0;
    end else if (miss_w && !seen_q) begin
      seen_q      <= 1'b1;
      fail_addr_q <= pop_w.addr[ADDR_W-1:0];
      fail_exp_q  <= pop_w.exp[DATA_W-1:0];
      fail_act_q  <= data_out_i;
    end
  end

  assign fail_addr_o = fail_addr_q;
  assign fail_exp_o  = fail_exp_q;
  assign fail_act_o  = fail_act_q;
`endif

endmodule

// File: rtl/mem_bist.sv
// March-style memory BIST: clear+verify zeros, then write+verify address pattern.
// Optional first-failure log outputs are enabled with the MEM_BIST_FAIL_LOG_EN macro.
module mem_bist
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  output logic              write,
  output logic              read,
  input  logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
`ifdef MEM_BIST_FAIL_LOG_EN
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_act,
`endif
  output logic [ADDR_W+1:0] err_cnt
);

  bist_state_t       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              start_acc;
  logic              phase_end;
  logic [DATA_W-1:0] exp_w;

  assign start_acc = start && ((state_q == IDLE) || (state_q == DONE));
  // cnt_q walks addresses in write/read phases and counts latency cycles in drain phases.
  assign phase_end = is_drain(state_q) ? (cnt_q == ADDR_W'(RD_LAT - 1)) : (&cnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if ((state_q == IDLE) || (state_q == DONE)) begin
      if (start) begin
        state_d = CLR_WR;
        cnt_d   = '0;
      end
    end else if (phase_end) begin
      state_d = next_phase(state_q);
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Status flags come from flops and rise the cycle after the final compare has settled.
  always_comb begin
    done_d = (state_q == DONE) && !start;
    pass_d = done_d && (err_cnt == '0);
  end

  always_comb begin
    write   = (state_q == CLR_WR) || (state_q == DA_WR);
    read    = (state_q == CLR_RD) || (state_q == DA_RD);
    addr    = (write || read) ? cnt_q : '0;
    data_in = (state_q == DA_WR) ? DATA_W'(cnt_q) : '0;
    exp_w   = (state_q == DA_RD) ? DATA_W'(cnt_q) : '0;
    busy    = is_active(state_q);
    done    = done_q;
    pass    = pass_q;
  end

  mem_bist_chk #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (start_acc),
    .rd_vld_i   (read),
    .rd_addr_i  (addr),
    .rd_exp_i   (exp_w),
    .data_out_i (data_out),
`ifdef MEM_BIST_FAIL_LOG_EN
    .fail_addr_o(fail_addr),
    .fail_exp_o (fail_exp),
    .fail_act_o (fail_act),
`endif
    .err_cnt_o  (err_cnt)
  );

endmodule

// File: tb/tb_mem_bist.sv
// Bench for mem_bist: two instances (RD_LAT=1 and RD_LAT=2) each on a behavioural 32x8 memory
// with selectable faults; fail-log checks are compiled in with MEM_BIST_FAIL_LOG_EN.
module tb_mem_bist;

  logic       clk;
  logic       rst_n;
  logic       start1, start2;
  logic [4:0] addr1, addr2;
  logic [7:0] data_in1, data_in2, data_out1, data_out2;
  logic       write1, write2, read1, read2;
  logic       busy1, busy2, done1, done2, pass1, pass2;
  logic [6:0] err1, err2;
`ifdef MEM_BIST_FAIL_LOG_EN
  logic [4:0] fa1, fa2;
  logic [7:0] fe1, fe2, fx1, fx2;
`endif

  int total = 0;
  int bad   = 0;
  int fault_mode = 0;  // 0 ideal, 1 bit0 stuck-at-1, 2 addr 5 reads 0xFF
  int n_wr, n_rd, n_strobe_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_bist #(.ADDR_W(5), .DATA_W(8), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .addr(addr1), .data_in(data_in1),
    .write(write1), .read(read1), .data_out(data_out1), .busy(busy1), .done(done1),
    .pass(pass1),
`ifdef MEM_BIST_FAIL_LOG_EN
    .fail_addr(fa1), .fail_exp(fe1), .fail_act(fx1),
`endif
    .err_cnt(err1)
  );

  mem_bist #(.ADDR_W(5), .DATA_W(8), .RD_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .addr(addr2), .data_in(data_in2),
    .write(write2), .read(read2), .data_out(data_out2), .busy(busy2), .done(done2),
    .pass(pass2),
`ifdef MEM_BIST_FAIL_LOG_EN
    .fail_addr(fa2), .fail_exp(fe2), .fail_act(fx2),
`endif
    .err_cnt(err2)
  );

  // Behavioural memories: latency 1 for dut1, latency 2 for dut2.
  logic [7:0] mem1 [32];
  logic [7:0] mem2 [32];
  logic [7:0] r1_d, s1_d, s2_d;
  logic [4:0] r1_a, s1_a, s2_a;

  function automatic logic [7:0] flt(input logic [7:0] d, input logic [4:0] a);
    if (fault_mode == 1) return d | 8'h01;
    if (fault_mode == 2 && a == 5'd5) return 8'hFF;
    return d;
  endfunction

  always @(posedge clk) begin
    if (write1) mem1[addr1] <= data_in1;
    if (read1) begin
      r1_d <= mem1[addr1];
      r1_a <= addr1;
    end
    if (write2) mem2[addr2] <= data_in2;
    s1_d <= mem2[addr2];
    s1_a <= addr2;
    s2_d <= s1_d;
    s2_a <= s1_a;
  end

  assign data_out1 = flt(r1_d, r1_a);
  assign data_out2 = flt(s2_d, s2_a);

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic sel_done(input int w);
    return (w == 1) ? done1 : done2;
  endfunction

  task automatic set_start(input int w, input logic v);
    if (w == 1) start1 = v;
    else        start2 = v;
  endtask

  task automatic sample_strobes(input int w);
    logic wr, rd;
    logic [4:0] a;
    logic [7:0] d;
    wr = (w == 1) ? write1 : write2;
    rd = (w == 1) ? read1 : read2;
    a  = (w == 1) ? addr1 : addr2;
    d  = (w == 1) ? data_in1 : data_in2;
    if (wr) n_wr++;
    if (rd) n_rd++;
    if ((wr && rd) || (!wr && !rd && (a != 5'd0 || d != 8'd0))) n_strobe_bad++;
  endtask

  // Pulses start (sampled at edge k) and returns the number of edges after k until done is seen.
  task automatic run_bist(input int w, input int extra_at, output int lat);
    lat = -1;
    n_wr = 0; n_rd = 0; n_strobe_bad = 0;
    @(posedge clk); #1 set_start(w, 1'b1);
    @(posedge clk); #1 set_start(w, 1'b0);
    check("busy_first_cycle", (w == 1) ? busy1 : busy2, 1);
    sample_strobes(w);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(posedge clk); #1;
      set_start(w, (cyc == extra_at));
      sample_strobes(w);
      if (sel_done(w)) begin
        lat = cyc;
        break;
      end
    end
    set_start(w, 1'b0);
    if (lat < 0) check("done_timeout", 0, 1);
  endtask

  task automatic check_image(input int w, input string name);
    int diffs = 0;
    for (int a = 0; a < 32; a++) begin
      logic [7:0] v;
      v = (w == 1) ? mem1[a] : mem2[a];
      if (v != 8'(a)) diffs++;
    end
    check(name, diffs, 0);
  endtask

  typedef struct {
    int         fault;
    int         extra_at;
    int         exp_err;
    logic       exp_pass;
    int         exp_lat;
    logic [4:0] exp_fa;
    logic [7:0] exp_fe;
    logic [7:0] exp_fx;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int lat;
    logic [6:0] err_hold;

    vecs[0] = '{fault: 0, extra_at: 0,  exp_err: 0,  exp_pass: 1'b1, exp_lat: 131,
                exp_fa: 5'd0, exp_fe: 8'h00, exp_fx: 8'h00};
    vecs[1] = '{fault: 1, extra_at: 0,  exp_err: 48, exp_pass: 1'b0, exp_lat: 131,
                exp_fa: 5'd0, exp_fe: 8'h00, exp_fx: 8'h01};
    vecs[2] = '{fault: 2, extra_at: 0,  exp_err: 2,  exp_pass: 1'b0, exp_lat: 131,
                exp_fa: 5'd5, exp_fe: 8'h00, exp_fx: 8'hFF};
    vecs[3] = '{fault: 0, extra_at: 40, exp_err: 0,  exp_pass: 1'b1, exp_lat: 131,
                exp_fa: 5'd0, exp_fe: 8'h00, exp_fx: 8'h00};
    vecs[4] = '{fault: 1, extra_at: 70, exp_err: 48, exp_pass: 1'b0, exp_lat: 131,
                exp_fa: 5'd0, exp_fe: 8'h00, exp_fx: 8'h01};

    rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0;
    #3;
    check("rst_outputs_dut1", {addr1, data_in1, write1, read1, busy1, done1, pass1, err1}, 0);
    check("rst_outputs_dut2", {addr2, data_in2, write2, read2, busy2, done2, pass2, err2}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("idle_after_reset", {busy1, done1, write1, read1}, 0);

    for (int i = 0; i < 5; i++) begin
      fault_mode = vecs[i].fault;
      run_bist(1, vecs[i].extra_at, lat);
      check($sformatf("v%0d_done_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_err_cnt", i), err1, vecs[i].exp_err);
      check($sformatf("v%0d_pass", i), pass1, vecs[i].exp_pass);
      check($sformatf("v%0d_busy_in_done", i), busy1, 0);
      check($sformatf("v%0d_writes", i), n_wr, 64);
      check($sformatf("v%0d_reads", i), n_rd, 64);
      check($sformatf("v%0d_strobe_rules", i), n_strobe_bad, 0);
      check_image(1, $sformatf("v%0d_mem_image", i));
`ifdef MEM_BIST_FAIL_LOG_EN
      check($sformatf("v%0d_fail_addr", i), fa1, vecs[i].exp_fa);
      check($sformatf("v%0d_fail_exp", i), fe1, vecs[i].exp_fe);
      check($sformatf("v%0d_fail_act", i), fx1, vecs[i].exp_fx);
`endif
      err_hold = err1;
      repeat (3) @(posedge clk);
      #1 check($sformatf("v%0d_done_hold", i), {done1, pass1, err1},
               {1'b1, vecs[i].exp_pass, err_hold});
    end

    // Abort mid DA_WR with a faulty memory: clear-phase errors must vanish on reset.
    fault_mode = 1;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    repeat (75) @(posedge clk);
    #1 check("pre_abort_err", err1, 32);
    check("pre_abort_write", write1, 1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs",
             {addr1, data_in1, write1, read1, busy1, done1, pass1, err1}, 0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    fault_mode = 0;
    run_bist(1, 0, lat);
    check("post_abort_latency", lat, 131);
    check("post_abort_pass", pass1, 1);
    check("post_abort_err", err1, 0);

    // Two-cycle read latency instance.
    run_bist(2, 0, lat);
    check("lat2_done_latency", lat, 133);
    check("lat2_pass", pass2, 1);
    check("lat2_err", err2, 0);
    check("lat2_strobe_rules", n_strobe_bad, 0);
    check_image(2, "lat2_mem_image");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
